// File: rtl/program_loader.sv
// Boot-time program loader: handshakes 0x99 over the UART, receives a little-endian
// byte count and the program words, writes them to program memory, then answers 0xAA.
module program_loader #(
   parameter int ADDR_W = 15
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [7:0]        i_rx_data,
   input  logic              i_rx_valid,
   input  logic              i_tx_busy,
   output logic [7:0]        o_tx_data,
   output logic              o_tx_start,
   output logic [31:0]       o_program_data_size,
   output logic              o_program_data_size_wren,
   output logic [ADDR_W-1:0] o_program_memory_addr,
   output logic [31:0]       o_program_memory_wdata,
   output logic              o_program_memory_wren,
   output logic              o_program_data_size_fetch_finished,
   output logic              o_program_data_fetch_finished
);

   typedef enum logic [2:0] {
      ST_SEND_99   = 3'd0,
      ST_RECV_SIZE = 3'd1,
      ST_RECV_PROG = 3'd2,
      ST_SEND_AA   = 3'd3,
      ST_DONE      = 3'd4
   } state_t;

   localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

   state_t            r_state;
   state_t            w_state_nxt;
   logic [1:0]        r_byte_cnt;
   logic [1:0]        w_byte_cnt_nxt;
   logic [23:0]       r_shift;
   logic [23:0]       w_shift_nxt;
   logic [29:0]       r_words_left;
   logic [29:0]       w_words_left_nxt;
   logic [7:0]        r_tx_data;
   logic [7:0]        w_tx_data_nxt;
   logic              r_tx_start;
   logic              w_tx_start_nxt;
   logic [31:0]       r_size;
   logic [31:0]       w_size_nxt;
   logic              r_size_wren;
   logic              w_size_wren_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] w_addr_nxt;
   logic [31:0]       r_wdata;
   logic [31:0]       w_wdata_nxt;
   logic              r_mem_wren;
   logic              w_mem_wren_nxt;
   logic              r_size_done;
   logic              w_size_done_nxt;
   logic              r_data_done;
   logic              w_data_done_nxt;
   logic [31:0]       w_word;
   logic              w_last_byte;

   // Places a received byte into the partial little-endian word at lane cnt.
   function automatic logic [23:0] insert_byte(input logic [23:0] shift,
                                               input logic [1:0]  cnt,
                                               input logic [7:0]  b);
      logic [23:0] res;
      res = shift;
      case (cnt)
         2'd0:    res[7:0]   = b;
         2'd1:    res[15:8]  = b;
         2'd2:    res[23:16] = b;
         default: res        = shift;
      endcase
      return res;
   endfunction

   assign w_word      = {i_rx_data, r_shift};
   assign w_last_byte = (r_byte_cnt == 2'd3);

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_SEND_99;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and next-value logic for every registered output and counter.
   always_comb begin
      w_state_nxt      = r_state;
      w_byte_cnt_nxt   = r_byte_cnt;
      w_shift_nxt      = r_shift;
      w_words_left_nxt = r_words_left;
      w_tx_data_nxt    = r_tx_data;
      w_tx_start_nxt   = 1'b0;
      w_size_nxt       = r_size;
      w_size_wren_nxt  = 1'b0;
      w_wdata_nxt      = r_wdata;
      w_mem_wren_nxt   = 1'b0;
      w_size_done_nxt  = r_size_done;
      w_data_done_nxt  = r_data_done;
      // The address moves on only after the cycle in which it was presented with a write.
      if (r_mem_wren) begin
         w_addr_nxt = r_addr + ADDR_ONE;
      end else begin
         w_addr_nxt = r_addr;
      end

      case (r_state)
         ST_SEND_99: begin
            if (!i_tx_busy) begin
               w_tx_data_nxt  = 8'h99;
               w_tx_start_nxt = 1'b1;
               w_byte_cnt_nxt = 2'd0;
               w_state_nxt    = ST_RECV_SIZE;
            end else begin
               w_tx_start_nxt = 1'b0;
            end
         end
         ST_RECV_SIZE: begin
            if (i_rx_valid && w_last_byte) begin
               w_size_nxt       = w_word;
               w_size_wren_nxt  = 1'b1;
               w_size_done_nxt  = 1'b1;
               w_words_left_nxt = w_word[31:2];
               w_byte_cnt_nxt   = 2'd0;
               if (w_word[31:2] == 30'd0) begin
                  w_state_nxt = ST_SEND_AA;
               end else begin
                  w_addr_nxt  = ADDR_ZERO;
                  w_state_nxt = ST_RECV_PROG;
               end
            end else if (i_rx_valid) begin
               w_shift_nxt    = insert_byte(r_shift, r_byte_cnt, i_rx_data);
               w_byte_cnt_nxt = r_byte_cnt + 2'd1;
            end else begin
               w_byte_cnt_nxt = r_byte_cnt;
            end
         end
         ST_RECV_PROG: begin
            if (i_rx_valid && w_last_byte) begin
               w_wdata_nxt      = w_word;
               w_mem_wren_nxt   = 1'b1;
               w_words_left_nxt = r_words_left - 30'd1;
               w_byte_cnt_nxt   = 2'd0;
               if (r_words_left == 30'd1) begin
                  w_state_nxt = ST_SEND_AA;
               end else begin
                  w_state_nxt = ST_RECV_PROG;
               end
            end else if (i_rx_valid) begin
               w_shift_nxt    = insert_byte(r_shift, r_byte_cnt, i_rx_data);
               w_byte_cnt_nxt = r_byte_cnt + 2'd1;
            end else begin
               w_byte_cnt_nxt = r_byte_cnt;
            end
         end
         ST_SEND_AA: begin
            if (!i_tx_busy) begin
               w_tx_data_nxt  = 8'hAA;
               w_tx_start_nxt = 1'b1;
               w_state_nxt    = ST_DONE;
            end else begin
               w_tx_start_nxt = 1'b0;
            end
         end
         ST_DONE: begin
            w_data_done_nxt = 1'b1;
         end
         default: begin
            w_state_nxt = ST_SEND_99;
         end
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_byte_cnt   <= 2'd0;
         r_shift      <= 24'd0;
         r_words_left <= 30'd0;
         r_tx_data    <= 8'd0;
         r_tx_start   <= 1'b0;
         r_size       <= 32'd0;
         r_size_wren  <= 1'b0;
         r_addr       <= ADDR_ZERO;
         r_wdata      <= 32'd0;
         r_mem_wren   <= 1'b0;
         r_size_done  <= 1'b0;
         r_data_done  <= 1'b0;
      end else begin
         r_byte_cnt   <= w_byte_cnt_nxt;
         r_shift      <= w_shift_nxt;
         r_words_left <= w_words_left_nxt;
         r_tx_data    <= w_tx_data_nxt;
         r_tx_start   <= w_tx_start_nxt;
         r_size       <= w_size_nxt;
         r_size_wren  <= w_size_wren_nxt;
         r_addr       <= w_addr_nxt;
         r_wdata      <= w_wdata_nxt;
         r_mem_wren   <= w_mem_wren_nxt;
         r_size_done  <= w_size_done_nxt;
         r_data_done  <= w_data_done_nxt;
      end
   end

   assign o_tx_data                          = r_tx_data;
   assign o_tx_start                         = r_tx_start;
   assign o_program_data_size                = r_size;
   assign o_program_data_size_wren           = r_size_wren;
   assign o_program_memory_addr              = r_addr;
   assign o_program_memory_wdata             = r_wdata;
   assign o_program_memory_wren              = r_mem_wren;
   assign o_program_data_size_fetch_finished = r_size_done;
   assign o_program_data_fetch_finished      = r_data_done;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: handshakes, size/word latency, empty and
// odd-sized loads, transmitter back-pressure and reset in the middle of a load.
module tb_program_loader;
   localparam int ADDR_W = 15;

   logic              clk;
   logic              i_reset;
   logic [7:0]        i_rx_data;
   logic              i_rx_valid;
   logic              i_tx_busy;
   logic [7:0]        o_tx_data;
   logic              o_tx_start;
   logic [31:0]       o_program_data_size;
   logic              o_program_data_size_wren;
   logic [ADDR_W-1:0] o_program_memory_addr;
   logic [31:0]       o_program_memory_wdata;
   logic              o_program_memory_wren;
   logic              o_size_ff;
   logic              o_data_ff;

   int          n_checks;
   int          n_failures;
   int          n_tx;
   int          n_wr;
   int          tx_base;
   int          wr_base;
   logic [31:0] mem [0:31];

   program_loader #(.ADDR_W(ADDR_W)) dut (
      .i_clk                              (clk),
      .i_reset                            (i_reset),
      .i_rx_data                          (i_rx_data),
      .i_rx_valid                         (i_rx_valid),
      .i_tx_busy                          (i_tx_busy),
      .o_tx_data                          (o_tx_data),
      .o_tx_start                         (o_tx_start),
      .o_program_data_size                (o_program_data_size),
      .o_program_data_size_wren           (o_program_data_size_wren),
      .o_program_memory_addr              (o_program_memory_addr),
      .o_program_memory_wdata             (o_program_memory_wdata),
      .o_program_memory_wren              (o_program_memory_wren),
      .o_program_data_size_fetch_finished (o_size_ff),
      .o_program_data_fetch_finished      (o_data_ff)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts transmit strobes and mirrors memory writes on the falling edge.
   always @(negedge clk) begin
      if (!i_reset) begin
         if (o_tx_start) n_tx <= n_tx + 1;
         if (o_program_memory_wren) begin
            n_wr <= n_wr + 1;
            mem[o_program_memory_addr[4:0]] <= o_program_memory_wdata;
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_failures++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      i_rx_data  = b;
      i_rx_valid = 1'b1;
      tick();
      i_rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      send_byte(w[7:0]);
      send_byte(w[15:8]);
      send_byte(w[23:16]);
      send_byte(w[31:24]);
   endtask

   task automatic wait_tx(input string tag, input logic [7:0] exp, input int budget);
      logic found;
      found = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (o_tx_start) begin
            found = 1'b1;
            break;
         end
      end
      check_eq({tag, "_seen"}, {31'd0, found}, 32'd1);
      if (found) check_eq({tag, "_data"}, {24'd0, o_tx_data}, {24'd0, exp});
   endtask

   task automatic do_reset();
      i_reset    = 1'b1;
      i_rx_valid = 1'b0;
      repeat (3) tick();
      check_eq("rst_tx_start", {31'd0, o_tx_start}, 32'd0);
      check_eq("rst_tx_data", {24'd0, o_tx_data}, 32'd0);
      check_eq("rst_size", o_program_data_size, 32'd0);
      check_eq("rst_addr", {17'd0, o_program_memory_addr}, 32'd0);
      check_eq("rst_wdata", o_program_memory_wdata, 32'd0);
      check_eq("rst_flags", {28'd0, o_program_data_size_wren, o_program_memory_wren,
                             o_size_ff, o_data_ff}, 32'd0);
      i_reset = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks   = 0;
      n_failures = 0;
      n_tx       = 0;
      n_wr       = 0;
      i_reset    = 1'b1;
      i_rx_data  = 8'd0;
      i_rx_valid = 1'b0;
      i_tx_busy  = 1'b0;

      // Two-word load.
      do_reset();
      wait_tx("t1_99", 8'h99, 2);
      check_eq("t1_levels_low", {30'd0, o_size_ff, o_data_ff}, 32'd0);
      send_word(32'h0000_0008);
      check_eq("t1_size_wren", {31'd0, o_program_data_size_wren}, 32'd1);
      check_eq("t1_size", o_program_data_size, 32'd8);
      check_eq("t1_size_ff", {31'd0, o_size_ff}, 32'd1);
      send_byte(8'h78);
      check_eq("t1_size_wren_1cyc", {31'd0, o_program_data_size_wren}, 32'd0);
      send_byte(8'h56);
      send_byte(8'h34);
      send_byte(8'h12);
      check_eq("t1_w0_wren", {31'd0, o_program_memory_wren}, 32'd1);
      check_eq("t1_w0_addr", {17'd0, o_program_memory_addr}, 32'd0);
      check_eq("t1_w0_data", o_program_memory_wdata, 32'h1234_5678);
      send_byte(8'hEF);
      check_eq("t1_addr_inc", {17'd0, o_program_memory_addr}, 32'd1);
      check_eq("t1_wren_1cyc", {31'd0, o_program_memory_wren}, 32'd0);
      send_byte(8'hBE);
      send_byte(8'hAD);
      send_byte(8'hDE);
      check_eq("t1_w1_wren", {31'd0, o_program_memory_wren}, 32'd1);
      check_eq("t1_w1_addr", {17'd0, o_program_memory_addr}, 32'd1);
      check_eq("t1_w1_data", o_program_memory_wdata, 32'hDEAD_BEEF);
      wait_tx("t1_aa", 8'hAA, 3);
      check_eq("t1_data_ff_pulse_cycle", {31'd0, o_data_ff}, 32'd0);
      tick();
      check_eq("t1_data_ff", {31'd0, o_data_ff}, 32'd1);
      check_eq("t1_tx_1cyc", {31'd0, o_tx_start}, 32'd0);
      check_eq("t1_writes", n_wr, 32'd2);

      // Empty program.
      do_reset();
      tx_base = n_tx;
      wr_base = n_wr;
      wait_tx("t2_99", 8'h99, 2);
      send_word(32'h0000_0000);
      check_eq("t2_size_wren", {31'd0, o_program_data_size_wren}, 32'd1);
      check_eq("t2_size", o_program_data_size, 32'd0);
      wait_tx("t2_aa", 8'hAA, 3);
      tick();
      check_eq("t2_data_ff", {31'd0, o_data_ff}, 32'd1);
      check_eq("t2_no_writes", n_wr - wr_base, 32'd0);

      // Size 6: one word, trailing bytes ignored once done.
      do_reset();
      tx_base = n_tx;
      wr_base = n_wr;
      wait_tx("t3_99", 8'h99, 2);
      send_word(32'h0000_0006);
      check_eq("t3_size", o_program_data_size, 32'd6);
      send_word(32'h0403_0201);
      check_eq("t3_w0_addr", {17'd0, o_program_memory_addr}, 32'd0);
      check_eq("t3_w0_data", o_program_memory_wdata, 32'h0403_0201);
      wait_tx("t3_aa", 8'hAA, 3);
      tick();
      send_byte(8'h05);
      send_byte(8'h06);
      repeat (4) tick();
      check_eq("t3_one_write", n_wr - wr_base, 32'd1);
      check_eq("t3_tx_count", n_tx - tx_base, 32'd2);
      check_eq("t3_levels", {30'd0, o_size_ff, o_data_ff}, 32'd3);

      // Transmitter busy during SEND_99, with stray rx bytes.
      i_tx_busy = 1'b1;
      do_reset();
      tx_base = n_tx;
      wr_base = n_wr;
      for (int i = 0; i < 20; i++) begin
         i_rx_valid = (i == 5) || (i == 6);
         i_rx_data  = (i == 5) ? 8'h11 : 8'h22;
         tick();
      end
      i_rx_valid = 1'b0;
      check_eq("t4_no_tx_while_busy", n_tx - tx_base, 32'd0);
      i_tx_busy = 1'b0;
      wait_tx("t4_99", 8'h99, 2);
      tick();
      check_eq("t4_single_pulse", {31'd0, o_tx_start}, 32'd0);
      send_word(32'h0000_0004);
      check_eq("t4_size", o_program_data_size, 32'd4);
      send_word(32'hCAFE_F00D);
      check_eq("t4_w0_addr", {17'd0, o_program_memory_addr}, 32'd0);
      check_eq("t4_w0_data", o_program_memory_wdata, 32'hCAFE_F00D);
      wait_tx("t4_aa", 8'hAA, 3);
      tick();
      check_eq("t4_tx_count", n_tx - tx_base, 32'd2);

      // Reset after two of four words, then a full reload.
      do_reset();
      wait_tx("t5_99a", 8'h99, 2);
      send_word(32'h0000_0010);
      send_word(32'h1111_1111);
      send_word(32'h2222_2222);
      do_reset();
      wr_base = n_wr;
      wait_tx("t5_99b", 8'h99, 2);
      send_word(32'h0000_0010);
      check_eq("t5_size", o_program_data_size, 32'd16);
      send_word(32'hA0A0_0001);
      check_eq("t5_w0_addr", {17'd0, o_program_memory_addr}, 32'd0);
      check_eq("t5_w0_data", o_program_memory_wdata, 32'hA0A0_0001);
      send_word(32'hA0A0_0002);
      send_word(32'hA0A0_0003);
      send_word(32'hA0A0_0004);
      check_eq("t5_w3_addr", {17'd0, o_program_memory_addr}, 32'd3);
      wait_tx("t5_aa", 8'hAA, 3);
      tick();
      check_eq("t5_writes", n_wr - wr_base, 32'd4);
      check_eq("t5_mem1", mem[1], 32'hA0A0_0002);
      check_eq("t5_mem3", mem[3], 32'hA0A0_0004);
      check_eq("t5_data_ff", {31'd0, o_data_ff}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
      $finish;
   end
endmodule
